dsp_alu_arbiter: RTL

- Shares one pipelined DSP logic/arithmetic unit (i8 AND/OR/XOR/ADD) between NREQ requesters.
- Round-robin arbitration, valid/ready request handshake, fixed-latency tagged responses.
- Sits between compiler-generated requester datapaths and a single DSP slice instance, so several IR ops map onto one physical DSP.

---
 rtl/dsp_arb_pkg.sv | 37 +++
 rtl/dsp_alu_arbiter_if.sv | 34 +++
 rtl/dsp_alu_pipe.sv | 75 +++++++
 rtl/dsp_alu_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/dsp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_arb_pkg
// Purpose  : Shared op encoding and the reference ALU function used by the
//            shared DSP pipeline.
// Contents : op_t (2-bit op code), OP_AND/OP_OR/OP_XOR/OP_ADD,
//            alu_calc() evaluated at MAXW bits; callers truncate to WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_arb_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND = 2'b00;
  localparam op_t OP_OR  = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_ADD = 2'b11;

  // Widest operand the function supports; WIDTH must not exceed this.
  localparam int MAXW = 32;

  // Truncating the result to WIDTH bits turns the ADD into a+b mod 2^WIDTH.
  function automatic logic [MAXW-1:0] alu_calc(input op_t op,
                                               input logic [MAXW-1:0] a,
                                               input logic [MAXW-1:0] b);
    logic [MAXW-1:0] y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_alu_arbiter_if
// Purpose  : Request/response bundle between NREQ requesters and the shared
//            DSP arbiter.
// Signals  : req_valid/req_ready (per-requester handshake), req_op/req_a/
//            req_b (packed per-requester slices), resp_valid (one-hot pulse),
//            resp_y (shared result).
// Modports : master = requester side, slave = arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface dsp_alu_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_y;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, resp_valid, resp_y
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, resp_valid, resp_y
  );
endinterface
`default_nettype wire

// File: rtl/dsp_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dsp_alu_pipe
// Purpose  : LAT-stage ALU pipeline with a valid+tag sideband; maps onto a
//            single DSP slice. Never stalls.
// Ports    : clock, reset (async, active-low)
//            in_valid/in_tag/in_op/in_a/in_b - op entering stage 1
//            out_valid/out_tag/out_y         - last stage (out_y holds its
//                                              value when no op is present)
//            busy                            - any stage holds a valid op
// Revision : 1.0 - initial release
// ============================================================================
module dsp_alu_pipe
  import dsp_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int TAGW  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAGW-1:0]  in_tag,
  input  op_t              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [TAGW-1:0]  out_tag,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);

  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAGW-1:0]  tag_q [LAT];
  logic [TAGW-1:0]  tag_d [LAT];
  logic [WIDTH-1:0] y_q   [LAT];
  logic [WIDTH-1:0] y_d   [LAT];
  logic [WIDTH-1:0] calc_y;

  // The result is formed on entry; later stages only carry it, so the last
  // stage is the response register for any LAT. Data moves only alongside a
  // valid bit, which keeps the output value stable between responses.
  always_comb begin
    calc_y   = WIDTH'(alu_calc(in_op, MAXW'(in_a), MAXW'(in_b)));
    vld_d[0] = in_valid;
    tag_d[0] = in_valid ? in_tag : tag_q[0];
    y_d[0]   = in_valid ? calc_y : y_q[0];
    for (int s = 1; s < LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      tag_d[s] = vld_q[s-1] ? tag_q[s-1] : tag_q[s];
      y_d[s]   = vld_q[s-1] ? y_q[s-1]   : y_q[s];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
        y_q[s]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      y_q   <= y_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];
  assign out_y     = y_q[LAT-1];
  assign busy      = |vld_q;

endmodule
`default_nettype wire

// File: rtl/dsp_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_alu_arbiter
// Purpose  : Round-robin sharing of one pipelined i8 AND/OR/XOR/ADD DSP unit
//            between NREQ requesters, with fixed-latency tagged responses.
// Ports    : clock, reset (async, active-low), en (grant enable)
//            bus        - dsp_alu_arbiter_if.slave request/response bundle
//            busy       - any pipeline stage holds a valid op
//            done_count - completed-op counter, wraps at 2^16
// Revision : 1.0 - initial release
// ============================================================================
module dsp_alu_arbiter
  import dsp_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  dsp_alu_arbiter_if.slave       bus,
  output logic                   busy,
  output logic [15:0]            done_count
);

  localparam int TAGW = $clog2(NREQ);

  logic [TAGW-1:0]  ptr_q, ptr_d;
  logic [15:0]      done_count_q, done_count_d;
  logic [TAGW-1:0]  grant_idx;
  logic             grant_any;
  logic [NREQ-1:0]  grant;
  op_t              sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             pipe_valid;
  logic [TAGW-1:0]  pipe_tag;
  logic [WIDTH-1:0] pipe_y;

  // Round-robin scan starting at ptr. Since ready is only raised for a valid
  // requester, a grant is also a transfer.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!grant_any && en && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = TAGW'(idx);
      end
    end
    grant = '0;
    // Hold ready low while the async reset is asserted.
    if (grant_any && reset) grant[grant_idx] = 1'b1;
    ptr_d = grant_any ? TAGW'((int'(grant_idx) + 1) % NREQ) : ptr_q;
  end

  assign bus.req_ready = grant;
  assign sel_op = op_t'(bus.req_op[2*int'(grant_idx) +: 2]);
  assign sel_a  = bus.req_a[WIDTH*int'(grant_idx) +: WIDTH];
  assign sel_b  = bus.req_b[WIDTH*int'(grant_idx) +: WIDTH];

  dsp_alu_pipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .TAGW  (TAGW)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (grant_any),
    .in_tag    (grant_idx),
    .in_op     (sel_op),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag),
    .out_y     (pipe_y),
    .busy      (busy)
  );

  // Responses come only from pipeline registers: no req_* to resp_* path.
  always_comb begin
    bus.resp_valid = '0;
    if (pipe_valid) bus.resp_valid[pipe_tag] = 1'b1;
    done_count_d = done_count_q + 16'(pipe_valid);
  end

  assign bus.resp_y = pipe_y;
  assign done_count = done_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q        <= '0;
      done_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      done_count_q <= done_count_d;
    end
  end

endmodule
`default_nettype wire
